// File: rtl/operand_streamer_pkg.sv
// Shared types for the operand streamer: stream modes and sequencer states.
package operand_streamer_pkg;

   typedef enum logic [1:0] {
      MODE_A    = 2'b00,
      MODE_B    = 2'b01,
      MODE_AB   = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/operand_streamer_if.sv
// Row stream from the operand streamer to the matrix array (valid/ready).
interface operand_streamer_if #(
   parameter int N  = 16,
   parameter int W  = 32,
   parameter int RW = 4
) ();
   logic                OUT_VALID;
   logic                OUT_READY;
   logic [N-1:0][W-1:0] OUT_DATA;
   logic                OUT_BANK;
   logic [RW-1:0]       OUT_ROW;
   logic                OUT_LAST;

   modport master (output OUT_VALID, OUT_DATA, OUT_BANK, OUT_ROW, OUT_LAST, input OUT_READY);
   modport slave  (input OUT_VALID, OUT_DATA, OUT_BANK, OUT_ROW, OUT_LAST, output OUT_READY);
endinterface

// File: rtl/operand_bank.sv
// One operand bank: ROWS x N words, single-word write, combinational full-row read.
module operand_bank #(
   parameter int N    = 16,
   parameter int W    = 32,
   parameter int ROWS = 16,
   localparam int RW  = $clog2(ROWS),
   localparam int LW  = $clog2(N)
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                wr_en,
   input  logic [RW-1:0]       wr_row,
   input  logic [LW-1:0]       wr_lane,
   input  logic [W-1:0]        wr_data,
   input  logic [RW-1:0]       rd_row,
   output logic [N-1:0][W-1:0] rd_data
);
   logic [N-1:0][W-1:0] mem [ROWS];

   always_ff @(posedge CLK) begin
      if (RSTN) begin
         for (int r = 0; r < ROWS; r++) mem[r] <= '0;
      end else if (wr_en) begin
         mem[wr_row][wr_lane] <= wr_data;
      end
   end

   // Read sees the pre-edge contents, so a same-edge write and load returns the old word.
   assign rd_data = mem[rd_row];
endmodule

// File: rtl/operand_streamer.sv
// Two operand banks plus a sequencer that streams a wrapping window of rows as A, B or interleaved beats.
module operand_streamer
   import operand_streamer_pkg::*;
#(
   parameter int N    = 16,
   parameter int W    = 32,
   parameter int ROWS = 16,
   localparam int RW  = $clog2(ROWS),
   localparam int LW  = $clog2(N)
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  WR_EN,
   input  logic                  WR_BANK,
   input  logic [RW-1:0]         WR_ROW,
   input  logic [LW-1:0]         WR_LANE,
   input  logic [W-1:0]          WR_DATA,
   input  logic                  START,
   input  logic [1:0]            MODE,
   input  logic [RW-1:0]         ROW_FIRST,
   input  logic [RW:0]           ROW_COUNT,
   input  logic                  ABORT,
   operand_streamer_if.master    out_if,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);
   localparam logic [RW:0] ROWS_W = ROWS[RW:0];

   state_e              state_q;
   mode_e               mode_q;
   logic                bank_q;
   logic [RW-1:0]       row_q;
   logic [RW+1:0]       remain_q;
   logic                valid_q;
   logic                last_q;
   logic [N-1:0][W-1:0] data_q;
   logic                done_q;
   logic                err_q;

   logic                ld_bank;
   logic [RW-1:0]       ld_row;
   logic [N-1:0][W-1:0] rd_a;
   logic [N-1:0][W-1:0] rd_b;
   logic [RW+1:0]       total_beats;
   logic                start_ok;
   logic                xfer;

   operand_bank #(.N(N), .W(W), .ROWS(ROWS)) u_bank_a (
      .CLK(CLK), .RSTN(RSTN), .wr_en(WR_EN & ~WR_BANK), .wr_row(WR_ROW),
      .wr_lane(WR_LANE), .wr_data(WR_DATA), .rd_row(ld_row), .rd_data(rd_a)
   );

   operand_bank #(.N(N), .W(W), .ROWS(ROWS)) u_bank_b (
      .CLK(CLK), .RSTN(RSTN), .wr_en(WR_EN & WR_BANK), .wr_row(WR_ROW),
      .wr_lane(WR_LANE), .wr_data(WR_DATA), .rd_row(ld_row), .rd_data(rd_b)
   );

   // Position of the beat to load next: the window start when idle, otherwise the successor
   // of the presented beat. Row increments wrap for free because ROWS is a power of two.
   always_comb begin
      ld_bank = bank_q;
      ld_row  = row_q;
      if (state_q == IDLE) begin
         ld_bank = (MODE == MODE_B);
         ld_row  = ROW_FIRST;
      end else if (mode_q == MODE_AB) begin
         ld_bank = ~bank_q;
         if (bank_q) ld_row = row_q + RW'(1);
      end else begin
         ld_row = row_q + RW'(1);
      end
   end

   assign total_beats = (MODE == MODE_AB) ? {ROW_COUNT, 1'b0} : {1'b0, ROW_COUNT};
   assign start_ok    = (ROW_COUNT != '0) && (ROW_COUNT <= ROWS_W) && (MODE != MODE_RSVD);
   assign xfer        = valid_q && out_if.OUT_READY;

   // Sequencer and output register; ABORT outranks both START and a coincident transfer.
   always_ff @(posedge CLK) begin
      if (RSTN) begin
         state_q  <= IDLE;
         mode_q   <= MODE_A;
         bank_q   <= 1'b0;
         row_q    <= '0;
         remain_q <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         data_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START && !ABORT) begin
                  if (start_ok) begin
                     state_q  <= RUN;
                     mode_q   <= mode_e'(MODE);
                     bank_q   <= ld_bank;
                     row_q    <= ld_row;
                     data_q   <= ld_bank ? rd_b : rd_a;
                     remain_q <= total_beats;
                     valid_q  <= 1'b1;
                     last_q   <= (total_beats == (RW+2)'(1));
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (ABORT) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
               end else if (xfer) begin
                  if (last_q) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     bank_q   <= ld_bank;
                     row_q    <= ld_row;
                     data_q   <= ld_bank ? rd_b : rd_a;
                     remain_q <= remain_q - (RW+2)'(1);
                     last_q   <= (remain_q == (RW+2)'(2));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_if.OUT_VALID = valid_q;
   assign out_if.OUT_DATA  = data_q;
   assign out_if.OUT_BANK  = bank_q;
   assign out_if.OUT_ROW   = row_q;
   assign out_if.OUT_LAST  = last_q;
   assign BUSY             = (state_q == RUN);
   assign DONE             = done_q;
   assign ERR              = err_q;
endmodule

// File: tb/tb_operand_streamer.sv
// Directed bench for operand_streamer: full A sweep, wrapped interleave, stalls, rejects, snapshot, abort, reset.
module tb_operand_streamer;
   localparam int N    = 16;
   localparam int W    = 32;
   localparam int ROWS = 16;
   localparam int RW   = $clog2(ROWS);
   localparam int LW   = $clog2(N);

   logic          CLK = 1'b0;
   logic          RSTN = 1'b1;
   logic          WR_EN = 1'b0;
   logic          WR_BANK = 1'b0;
   logic [RW-1:0] WR_ROW = '0;
   logic [LW-1:0] WR_LANE = '0;
   logic [W-1:0]  WR_DATA = '0;
   logic          START = 1'b0;
   logic [1:0]    MODE = 2'b00;
   logic [RW-1:0] ROW_FIRST = '0;
   logic [RW:0]   ROW_COUNT = '0;
   logic          ABORT = 1'b0;
   logic          BUSY, DONE, ERR;

   int checks = 0;
   int errors = 0;

   operand_streamer_if #(.N(N), .W(W), .RW(RW)) out_if ();

   operand_streamer #(.N(N), .W(W), .ROWS(ROWS)) dut (
      .CLK(CLK), .RSTN(RSTN), .WR_EN(WR_EN), .WR_BANK(WR_BANK), .WR_ROW(WR_ROW),
      .WR_LANE(WR_LANE), .WR_DATA(WR_DATA), .START(START), .MODE(MODE),
      .ROW_FIRST(ROW_FIRST), .ROW_COUNT(ROW_COUNT), .ABORT(ABORT),
      .out_if(out_if), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one edge and settle just past it, where both driving and sampling happen.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [N*W-1:0] exp_row(input logic bank, input int row);
      logic [N*W-1:0] r;
      for (int l = 0; l < N; l++)
         r[l*W +: W] = (bank ? 32'h8000_0000 : 32'h0) | 32'(row * 256 + l);
      return r;
   endfunction

   task automatic write_word(input logic bank, input int row, input int lane, input logic [W-1:0] data);
      WR_EN   = 1'b1;
      WR_BANK = bank;
      WR_ROW  = RW'(row);
      WR_LANE = LW'(lane);
      WR_DATA = data;
      tick();
      WR_EN   = 1'b0;
   endtask

   task automatic fill_banks();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < ROWS; r++)
            for (int l = 0; l < N; l++)
               write_word(b[0], r, l, (b == 1 ? 32'h8000_0000 : 32'h0) | 32'(r * 256 + l));
   endtask

   task automatic start_stream(input logic [1:0] mode, input int first, input int count);
      START     = 1'b1;
      MODE      = mode;
      ROW_FIRST = RW'(first);
      ROW_COUNT = (RW+1)'(count);
      tick();
      START     = 1'b0;
   endtask

   task automatic test_reset();
      RSTN = 1'b1;
      tick();
      tick();
      checks++;
      if ({out_if.OUT_VALID, out_if.OUT_BANK, out_if.OUT_ROW, out_if.OUT_LAST, BUSY, DONE, ERR} !== '0 ||
          out_if.OUT_DATA !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b bank=%b row=%0d last=%b busy=%b done=%b err=%b, want all 0",
                  out_if.OUT_VALID, out_if.OUT_BANK, out_if.OUT_ROW, out_if.OUT_LAST, BUSY, DONE, ERR);
      end
      RSTN = 1'b0;
      tick();
   endtask

   task automatic test_a_full();
      out_if.OUT_READY = 1'b1;
      start_stream(2'b00, 0, 16);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_if.OUT_VALID !== 1'b1 || BUSY !== 1'b1 || out_if.OUT_BANK !== 1'b0 ||
             out_if.OUT_ROW !== RW'(i) || out_if.OUT_LAST !== (i == 15) ||
             out_if.OUT_DATA !== exp_row(1'b0, i)) begin
            errors++;
            $display("[TB] FAIL a_full beat %0d: got v=%b busy=%b bank=%b row=%0d last=%b lane0=%h, want v=1 busy=1 bank=0 row=%0d last=%b lane0=%h",
                     i, out_if.OUT_VALID, BUSY, out_if.OUT_BANK, out_if.OUT_ROW, out_if.OUT_LAST,
                     out_if.OUT_DATA[0], i, (i == 15), 32'(i * 256));
         end
         tick();
      end
      checks++;
      if (DONE !== 1'b1 || out_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("[TB] FAIL a_full_done: got done=%b valid=%b busy=%b, want 1 0 0", DONE, out_if.OUT_VALID, BUSY);
      end
      tick();
      checks++;
      if (DONE !== 1'b0) begin
         errors++;
         $display("[TB] FAIL a_full_done_pulse: got done=%b, want 0", DONE);
      end
   endtask

   task automatic test_interleave_wrap();
      out_if.OUT_READY = 1'b1;
      start_stream(2'b10, 14, 3);
      for (int i = 0; i < 6; i++) begin
         logic exp_bank;
         int   exp_r;
         exp_bank = i[0];
         exp_r    = (14 + i / 2) % ROWS;
         checks++;
         if (out_if.OUT_VALID !== 1'b1 || out_if.OUT_BANK !== exp_bank || out_if.OUT_ROW !== RW'(exp_r) ||
             out_if.OUT_LAST !== (i == 5) || out_if.OUT_DATA !== exp_row(exp_bank, exp_r)) begin
            errors++;
            $display("[TB] FAIL interleave beat %0d: got v=%b bank=%b row=%0d last=%b lane0=%h, want v=1 bank=%b row=%0d last=%b",
                     i, out_if.OUT_VALID, out_if.OUT_BANK, out_if.OUT_ROW, out_if.OUT_LAST,
                     out_if.OUT_DATA[0], exp_bank, exp_r, (i == 5));
         end
         tick();
      end
      checks++;
      if (DONE !== 1'b1 || out_if.OUT_VALID !== 1'b0) begin
         errors++;
         $display("[TB] FAIL interleave_done: got done=%b valid=%b, want 1 0", DONE, out_if.OUT_VALID);
      end
      tick();
   endtask

   task automatic test_stalls_b();
      int idx = 0;
      int budget = 0;
      out_if.OUT_READY = 1'b0;
      start_stream(2'b01, 5, 4);
      while (idx < 4 && budget < 200) begin
         int r;
         r = 5 + idx;
         checks++;
         if (out_if.OUT_VALID !== 1'b1 || out_if.OUT_BANK !== 1'b1 || out_if.OUT_ROW !== RW'(r) ||
             out_if.OUT_LAST !== (idx == 3) || out_if.OUT_DATA !== exp_row(1'b1, r)) begin
            errors++;
            $display("[TB] FAIL stall beat %0d cycle %0d: got v=%b bank=%b row=%0d last=%b lane0=%h, want v=1 bank=1 row=%0d last=%b",
                     idx, budget, out_if.OUT_VALID, out_if.OUT_BANK, out_if.OUT_ROW, out_if.OUT_LAST,
                     out_if.OUT_DATA[0], r, (idx == 3));
         end
         out_if.OUT_READY = (budget < 2) ? 1'b0 : 1'($urandom_range(0, 1));
         tick();
         if (out_if.OUT_READY) idx++;
         budget++;
      end
      checks++;
      if (idx != 4 || DONE !== 1'b1 || out_if.OUT_VALID !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_done: got beats=%0d done=%b valid=%b, want 4 1 0", idx, DONE, out_if.OUT_VALID);
      end
      out_if.OUT_READY = 1'b1;
      tick();
   endtask

   task automatic test_reject();
      logic [1:0] modes [3] = '{2'b00, 2'b00, 2'b11};
      int         counts[3] = '{0, 17, 4};
      for (int k = 0; k < 3; k++) begin
         start_stream(modes[k], 2, counts[k]);
         checks++;
         if (ERR !== 1'b1 || BUSY !== 1'b0 || out_if.OUT_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reject %0d: got err=%b busy=%b valid=%b, want 1 0 0", k, ERR, BUSY, out_if.OUT_VALID);
         end
         tick();
         checks++;
         if (ERR !== 1'b0 || BUSY !== 1'b0 || out_if.OUT_VALID !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reject_pulse %0d: got err=%b busy=%b valid=%b, want 0 0 0", k, ERR, BUSY, out_if.OUT_VALID);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [N*W-1:0] want;
      out_if.OUT_READY = 1'b0;
      start_stream(2'b00, 3, 2);
      write_word(1'b0, 3, 0, 32'h0000_DEAD);
      tick();
      checks++;
      if (out_if.OUT_ROW !== RW'(3) || out_if.OUT_DATA !== exp_row(1'b0, 3)) begin
         errors++;
         $display("[TB] FAIL snapshot_held: got row=%0d lane0=%h, want row=3 lane0=%h",
                  out_if.OUT_ROW, out_if.OUT_DATA[0], 32'h300);
      end
      out_if.OUT_READY = 1'b1;
      tick();
      tick();
      start_stream(2'b00, 3, 1);
      want = exp_row(1'b0, 3);
      want[W-1:0] = 32'h0000_DEAD;
      checks++;
      if (out_if.OUT_VALID !== 1'b1 || out_if.OUT_DATA !== want) begin
         errors++;
         $display("[TB] FAIL snapshot_rerun: got valid=%b lane0=%h, want 1 0000dead", out_if.OUT_VALID, out_if.OUT_DATA[0]);
      end
      tick();
      write_word(1'b0, 3, 0, 32'h0000_0300);
   endtask

   task automatic test_abort();
      out_if.OUT_READY = 1'b1;
      start_stream(2'b00, 0, 8);
      tick();
      tick();
      checks++;
      if (out_if.OUT_ROW !== RW'(2) || out_if.OUT_VALID !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_setup: got row=%0d valid=%b, want 2 1", out_if.OUT_ROW, out_if.OUT_VALID);
      end
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      checks++;
      if (out_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort: got valid=%b busy=%b done=%b, want 0 0 0", out_if.OUT_VALID, BUSY, DONE);
      end
      tick();
      checks++;
      if (DONE !== 1'b0 || out_if.OUT_VALID !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_no_done: got done=%b valid=%b, want 0 0", DONE, out_if.OUT_VALID);
      end
      ABORT = 1'b1;
      start_stream(2'b00, 0, 4);
      ABORT = 1'b0;
      checks++;
      if (out_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_over_start: got valid=%b busy=%b err=%b, want 0 0 0", out_if.OUT_VALID, BUSY, ERR);
      end
   endtask

   task automatic test_reset_mid();
      out_if.OUT_READY = 1'b1;
      start_stream(2'b10, 0, 4);
      tick();
      RSTN = 1'b1;
      tick();
      RSTN = 1'b0;
      checks++;
      if (out_if.OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || out_if.OUT_DATA !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid: got valid=%b busy=%b done=%b lane0=%h, want 0 0 0 0",
                  out_if.OUT_VALID, BUSY, DONE, out_if.OUT_DATA[0]);
      end
      tick();
      start_stream(2'b10, 7, 2);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_if.OUT_VALID !== 1'b1 || out_if.OUT_DATA !== '0) begin
            errors++;
            $display("[TB] FAIL cleared_bank beat %0d: got valid=%b lane0=%h, want 1 0", i, out_if.OUT_VALID, out_if.OUT_DATA[0]);
         end
         tick();
      end
      checks++;
      if (DONE !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cleared_done: got done=%b, want 1", DONE);
      end
   endtask

   initial begin
      out_if.OUT_READY = 1'b0;
      test_reset();
      fill_banks();
      test_a_full();
      test_interleave_wrap();
      test_stalls_b();
      test_reject();
      test_snapshot();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/operand_streamer.md
# operand_streamer

Parametrised successor to the fixed 16-row A/B operand register file feeding the SIMD matrix datapath. Holds two operand banks (A and B), each loaded word-by-word over a write port. On command, an internal sequencer streams a programmable window of rows to the matrix array over a valid/ready handshake. Supports A-only, B-only and A/B-interleaved modes with modulo row wrap, replacing the external SEQ_A/SEQ_B/MATAB_MUX control.

## Interface
- N, 16: lanes per row (words per output beat)
- W, 32: word width in bits
- ROWS, 16: rows per bank; power of two, ≥2
- RW = $clog2(ROWS), LW = $clog2(N): derived localparams

- CLK  in  1  clock; all logic on rising edge
- RSTN  in  1  synchronous, active-high reset (asserted = 1 resets)
- WR_EN  in  1  word write strobe
- WR_BANK  in  1  0 = A, 1 = B
- WR_ROW  in  RW  row index
- WR_LANE  in  LW  lane index
- WR_DATA  in  W  write data
- START  in  1  start stream (sampled in IDLE only)
- MODE  in  2  00 A-only, 01 B-only, 10 interleave A,B, 11 reserved
- ROW_FIRST  in  RW  first row of window
- ROW_COUNT  in  RW+1  rows in window, legal 1..ROWS
- ABORT  in  1  terminate stream
- OUT_VALID  out  1  beat valid
- OUT_READY  in  1  consumer ready
- OUT_DATA  out  N×W  packed [N-1:0][W-1:0] row
- OUT_BANK  out  1  bank of current beat
- OUT_ROW  out  RW  row of current beat
- OUT_LAST  out  1  final beat of stream
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse after final handshake
- ERR  out  1  one-cycle pulse on rejected START

## Operation
- Storage: 2 × ROWS × N words. Write lands at edge where WR_EN = 1; writes accepted in any state, including RUN.
- States: IDLE, RUN. START/MODE/ROW_FIRST/ROW_COUNT captured at START edge.
- IDLE → RUN: START = 1, ROW_COUNT in 1..ROWS, MODE ≠ 11. First beat loaded into output register at same edge.
- Rejected START (ROW_COUNT = 0, ROW_COUNT > ROWS, or MODE = 11): stay IDLE, ERR = 1 for one cycle, no beats.
- START while RUN: ignored, no ERR.
- Beat order: A-only A[r0], A[r0+1], …; B-only likewise on B; interleave A[r0], B[r0], A[r0+1], B[r0+1], …. Row = (ROW_FIRST + i) mod ROWS (wrap). Total beats = ROW_COUNT, or 2·ROW_COUNT in interleave.
- Handshake: transfer when OUT_VALID & OUT_READY. OUT_DATA/OUT_BANK/OUT_ROW/OUT_LAST stable while OUT_VALID & !OUT_READY. OUT_VALID never drops without transfer except on ABORT/reset.
- On non-final transfer: next beat loaded same edge. On final transfer (OUT_LAST): → IDLE, OUT_VALID = 0, DONE = 1 next cycle.
- OUT_DATA is a registered snapshot: a write to the row currently presented does not alter OUT_DATA; it affects later loads only.
- ABORT in RUN: → IDLE next edge, OUT_VALID = 0, no DONE. ABORT has priority over a coincident transfer. ABORT in IDLE: no effect; ABORT has priority over START.
- RSTN: banks cleared to 0, state IDLE, all outputs 0. Reset mid-stream discards the stream, no DONE.

## Timing
- START at edge t → OUT_VALID = 1 from cycle t+1, BUSY = 1 from t+1.
- Throughput one beat/cycle with OUT_READY held high; interleave 2·ROW_COUNT cycles.
- Write at edge t visible to any load at edge ≥ t+1. Write and load of same word at same edge: load gets old value.
- DONE/ERR: exactly one cycle, registered.
- Reset values: OUT_VALID, OUT_DATA, OUT_BANK, OUT_ROW, OUT_LAST, BUSY, DONE, ERR all 0.

## Structure
- Package operand_streamer_pkg: mode_e (MODE_A, MODE_B, MODE_AB, MODE_RSVD), state_e (IDLE, RUN).
- Sub-module operand_bank: ROWS × N × W storage, one word write port, one combinational full-row read port; instantiated twice (A, B).
- Top: sequencer (row counter, bank toggle, beat counter), output register, status pulses.

## Test plan
- Fill A[r][l] = 0x100·r + l, B = 0x8000_0000 | A; START MODE=00, ROW_FIRST=0, ROW_COUNT=16, READY=1 → 16 beats rows 0..15, OUT_LAST on row 15, DONE next cycle.
- MODE=10, ROW_FIRST=14, ROW_COUNT=3 → beats A14, B14, A15, B15, A0, B0 (wrap), OUT_LAST on B0.
- Random OUT_READY stalls on MODE=01 → outputs held stable during stalls; beat sequence and count unchanged.
- ROW_COUNT=0, then ROW_COUNT=17, then MODE=11 → ERR pulse each, BUSY stays 0, no OUT_VALID.
- Write A[3][0]=0xDEAD while A3 presented and stalled → OUT_DATA keeps old word; rerun shows 0xDEAD.
- ABORT on beat 2 of 8, and RSTN mid-stream → OUT_VALID 0 next cycle, no DONE; after reset all bank reads 0.
